// File: rtl/alarm_if.sv
// Signal bundle between the alarm controller and its surroundings: user buttons,
// the running time, the timekeeper load port, the alarm state and the display source.
interface alarm_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_snooze;
  logic       btn_alarm_en;
  logic [5:0] cur_sec;
  logic [5:0] cur_min;
  logic [4:0] cur_hr;
  logic       load;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       ringing;
  logic [2:0] mode;
  logic [4:0] disp_hr;
  logic [5:0] disp_min;

  modport master (
    output btn_mode, btn_inc, btn_snooze, btn_alarm_en, cur_sec, cur_min, cur_hr,
    input  load, load_hr, load_min, alarm_hr, alarm_min, alarm_en, ringing, mode,
           disp_hr, disp_min
  );

  modport slave (
    input  btn_mode, btn_inc, btn_snooze, btn_alarm_en, cur_sec, cur_min, cur_hr,
    output load, load_hr, load_min, alarm_hr, alarm_min, alarm_en, ringing, mode,
           disp_hr, disp_min
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm-clock mode controller: time/alarm set sequencing, timekeeper load pulse,
// alarm match with ring/snooze/auto-stop, and display source selection.
//
// state     | meaning
// RUN       | normal timekeeping, watching for an alarm match
// SET_T_HR  | editing hour of the time to load
// SET_T_MIN | editing minute of the time to load
// SET_A_HR  | editing alarm hour (first cycle carries the load pulse)
// SET_A_MIN | editing alarm minute
// RING      | alarm sounding, counting towards auto-stop
// SNOOZE    | silent, waiting for the snooze target minute
module alarm_ctrl #(
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input logic    clk_1hz,
  input logic    reset,
  alarm_if.slave bus
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_T_HR  = 3'd1,
    SET_T_MIN = 3'd2,
    SET_A_HR  = 3'd3,
    SET_A_MIN = 3'd4,
    RING      = 3'd5,
    SNOOZE    = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] edit_hr_q, edit_hr_d;
  logic [5:0] edit_min_q, edit_min_d;
  logic [4:0] alarm_hr_q, alarm_hr_d;
  logic [5:0] alarm_min_q, alarm_min_d;
  logic       alarm_en_q, alarm_en_d;
  logic       load_q, load_d;
  logic [4:0] load_hr_q, load_hr_d;
  logic [5:0] load_min_q, load_min_d;
  logic [4:0] snz_hr_q, snz_hr_d;
  logic [5:0] snz_min_q, snz_min_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;

  logic       match, snz_hit;
  logic [6:0] snz_sum, snz_wrap;
  logic [4:0] snz_hr_calc;
  logic [5:0] snz_min_calc;

  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      edit_hr_q   <= '0;
      edit_min_q  <= '0;
      alarm_hr_q  <= '0;
      alarm_min_q <= '0;
      alarm_en_q  <= 1'b0;
      load_q      <= 1'b0;
      load_hr_q   <= '0;
      load_min_q  <= '0;
      snz_hr_q    <= '0;
      snz_min_q   <= '0;
      ring_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      edit_hr_q   <= edit_hr_d;
      edit_min_q  <= edit_min_d;
      alarm_hr_q  <= alarm_hr_d;
      alarm_min_q <= alarm_min_d;
      alarm_en_q  <= alarm_en_d;
      load_q      <= load_d;
      load_hr_q   <= load_hr_d;
      load_min_q  <= load_min_d;
      snz_hr_q    <= snz_hr_d;
      snz_min_q   <= snz_min_d;
      ring_cnt_q  <= ring_cnt_d;
    end
  end

  always_comb begin
    match   = alarm_en_q && (bus.cur_hr == alarm_hr_q) && (bus.cur_min == alarm_min_q)
              && (bus.cur_sec == 6'd0);
    snz_hit = (bus.cur_hr == snz_hr_q) && (bus.cur_min == snz_min_q) && (bus.cur_sec == 6'd0);

    // Snooze target minute may roll into the next hour, and 23h rolls to 0h.
    snz_sum  = {1'b0, bus.cur_min} + 7'(SNOOZE_MIN);
    snz_wrap = snz_sum - 7'd60;
    if (snz_sum >= 7'd60) begin
      snz_min_calc = snz_wrap[5:0];
      snz_hr_calc  = (bus.cur_hr == 5'd23) ? 5'd0 : bus.cur_hr + 5'd1;
    end else begin
      snz_min_calc = snz_sum[5:0];
      snz_hr_calc  = bus.cur_hr;
    end
  end

  always_comb begin
    state_d     = state_q;
    edit_hr_d   = edit_hr_q;
    edit_min_d  = edit_min_q;
    alarm_hr_d  = alarm_hr_q;
    alarm_min_d = alarm_min_q;
    alarm_en_d  = alarm_en_q;
    load_d      = 1'b0;
    load_hr_d   = load_hr_q;
    load_min_d  = load_min_q;
    snz_hr_d    = snz_hr_q;
    snz_min_d   = snz_min_q;
    ring_cnt_d  = ring_cnt_q;

    // alarm_en toggle outranks every other button and blocks them that cycle.
    if (bus.btn_alarm_en) begin
      alarm_en_d = ~alarm_en_q;
      if (alarm_en_q && (state_q == RING || state_q == SNOOZE)) state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (match) begin
            state_d    = RING;
            ring_cnt_d = '0;
          end else if (bus.btn_mode) begin
            state_d    = SET_T_HR;
            edit_hr_d  = bus.cur_hr;
            edit_min_d = bus.cur_min;
          end
        end
        SET_T_HR: begin
          if (bus.btn_mode) state_d = SET_T_MIN;
          else if (bus.btn_inc) edit_hr_d = (edit_hr_q == 5'd23) ? 5'd0 : edit_hr_q + 5'd1;
        end
        SET_T_MIN: begin
          if (bus.btn_mode) begin
            state_d    = SET_A_HR;
            load_d     = 1'b1;
            load_hr_d  = edit_hr_q;
            load_min_d = edit_min_q;
          end else if (bus.btn_inc) begin
            edit_min_d = (edit_min_q == 6'd59) ? 6'd0 : edit_min_q + 6'd1;
          end
        end
        SET_A_HR: begin
          if (bus.btn_mode) state_d = SET_A_MIN;
          else if (bus.btn_inc) alarm_hr_d = (alarm_hr_q == 5'd23) ? 5'd0 : alarm_hr_q + 5'd1;
        end
        SET_A_MIN: begin
          if (bus.btn_mode) state_d = RUN;
          else if (bus.btn_inc) alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
        end
        RING: begin
          if (bus.btn_snooze) begin
            state_d   = SNOOZE;
            snz_hr_d  = snz_hr_calc;
            snz_min_d = snz_min_calc;
          end else if (ring_cnt_q == 8'(RING_TIMEOUT - 1)) begin
            state_d = RUN;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
        SNOOZE: begin
          if (snz_hit) begin
            state_d    = RING;
            ring_cnt_d = '0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.mode      = state_q;
  assign bus.ringing   = (state_q == RING);
  assign bus.alarm_hr  = alarm_hr_q;
  assign bus.alarm_min = alarm_min_q;
  assign bus.alarm_en  = alarm_en_q;
  assign bus.load      = load_q;
  assign bus.load_hr   = load_hr_q;
  assign bus.load_min  = load_min_q;

  always_comb begin
    unique case (state_q)
      SET_T_HR, SET_T_MIN: begin
        bus.disp_hr  = edit_hr_q;
        bus.disp_min = edit_min_q;
      end
      SET_A_HR, SET_A_MIN: begin
        bus.disp_hr  = alarm_hr_q;
        bus.disp_min = alarm_min_q;
      end
      default: begin
        bus.disp_hr  = bus.cur_hr;
        bus.disp_min = bus.cur_min;
      end
    endcase
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: a minute-arithmetic reference model checked every
// cycle, plus hand-computed literal checks for the key scenarios.
module tb_alarm_ctrl;
  localparam int RING_TIMEOUT = 60;
  localparam int SNOOZE_MIN   = 5;

  logic clk_1hz = 1'b0;
  logic reset   = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  alarm_if bus ();

  alarm_ctrl #(.RING_TIMEOUT(RING_TIMEOUT), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clk_1hz (clk_1hz),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: mode numbers, time in total minutes, ring time remaining.
  int m_mode, m_en, m_ahr, m_amin, m_ehr, m_emin;
  int m_load, m_lhr, m_lmin, m_tgt, m_left;

  always @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_en = 0; m_ahr = 0; m_amin = 0; m_ehr = 0; m_emin = 0;
      m_load = 0; m_lhr = 0; m_lmin = 0; m_tgt = 0; m_left = 0;
    end else begin
      int now;
      bit at_alarm;
      now      = bus.cur_hr * 60 + bus.cur_min;
      at_alarm = (m_en != 0) && now == m_ahr * 60 + m_amin && bus.cur_sec == 0;
      m_load   = 0;
      if (bus.btn_alarm_en) begin
        m_en = 1 - m_en;
        if (m_en == 0 && m_mode >= 5) m_mode = 0;
      end else begin
        case (m_mode)
          0: if (at_alarm) begin m_mode = 5; m_left = RING_TIMEOUT; end
             else if (bus.btn_mode) begin m_mode = 1; m_ehr = bus.cur_hr; m_emin = bus.cur_min; end
          1: if (bus.btn_mode) m_mode = 2; else if (bus.btn_inc) m_ehr = (m_ehr + 1) % 24;
          2: if (bus.btn_mode) begin m_mode = 3; m_load = 1; m_lhr = m_ehr; m_lmin = m_emin; end
             else if (bus.btn_inc) m_emin = (m_emin + 1) % 60;
          3: if (bus.btn_mode) m_mode = 4; else if (bus.btn_inc) m_ahr = (m_ahr + 1) % 24;
          4: if (bus.btn_mode) m_mode = 0; else if (bus.btn_inc) m_amin = (m_amin + 1) % 60;
          5: if (bus.btn_snooze) begin m_mode = 6; m_tgt = (now + SNOOZE_MIN) % 1440; end
             else begin m_left--; if (m_left == 0) m_mode = 0; end
          6: if (now == m_tgt && bus.cur_sec == 0) begin m_mode = 5; m_left = RING_TIMEOUT; end
          default: m_mode = 0;
        endcase
      end
    end
  end

  always @(negedge clk_1hz) begin
    int dh, dm;
    if (m_mode == 1 || m_mode == 2) begin dh = m_ehr; dm = m_emin; end
    else if (m_mode == 3 || m_mode == 4) begin dh = m_ahr; dm = m_amin; end
    else begin dh = bus.cur_hr; dm = bus.cur_min; end
    chk("model_mode", bus.mode, m_mode);
    chk("model_ringing", bus.ringing, m_mode == 5 ? 1 : 0);
    chk("model_alarm_en", bus.alarm_en, m_en);
    chk("model_alarm_time", bus.alarm_hr * 100 + bus.alarm_min, m_ahr * 100 + m_amin);
    chk("model_load", bus.load, m_load);
    if (m_load != 0) chk("model_load_time", bus.load_hr * 100 + bus.load_min, m_lhr * 100 + m_lmin);
    chk("model_disp", bus.disp_hr * 100 + bus.disp_min, dh * 100 + dm);
  end

  // Buttons are applied 2 time units after a rising edge and sampled at the next one.
  task automatic press(input logic [3:0] b);
    {bus.btn_alarm_en, bus.btn_snooze, bus.btn_mode, bus.btn_inc} = b;
    @(posedge clk_1hz); #2;
    {bus.btn_alarm_en, bus.btn_snooze, bus.btn_mode, bus.btn_inc} = 4'b0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) press(4'b0000);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.cur_hr  = 5'(h);
    bus.cur_min = 6'(m);
    bus.cur_sec = 6'(s);
  endtask

  localparam logic [3:0] B_AE = 4'b1000, B_SN = 4'b0100, B_MD = 4'b0010, B_IN = 4'b0001;

  initial begin
    int cnt;
    {bus.btn_alarm_en, bus.btn_snooze, bus.btn_mode, bus.btn_inc} = 4'b0000;
    set_time(10, 15, 30);
    @(posedge clk_1hz); #2;
    chk("reset_mode", bus.mode, 0);
    chk("reset_load", bus.load, 0);
    reset = 1'b0;
    idle(1);

    // Set sequence from 10:15.
    press(B_MD); press(B_IN); press(B_IN); press(B_IN);
    press(B_MD); press(B_IN); press(B_IN); press(B_MD);
    chk("set_load", bus.load, 1);
    chk("set_load_hr", bus.load_hr, 13);
    chk("set_load_min", bus.load_min, 17);
    chk("set_mode", bus.mode, 3);
    idle(1);
    chk("set_load_drop", bus.load, 0);
    for (int i = 0; i < 7; i++) press(B_IN);
    press(B_MD);
    for (int i = 0; i < 30; i++) press(B_IN);
    chk("alarm_min_edit_disp", bus.disp_min, 30);
    press(B_MD);
    press(B_AE);
    chk("alarm_set", bus.alarm_hr * 100 + bus.alarm_min, 730);
    chk("alarm_en_on", bus.alarm_en, 1);

    // Edit wrap on both fields.
    set_time(23, 59, 10);
    press(B_MD); press(B_IN); press(B_MD); press(B_IN); press(B_MD);
    chk("wrap_load", bus.load, 1);
    chk("wrap_load_time", bus.load_hr * 100 + bus.load_min, 0);
    press(B_MD); press(B_MD);
    chk("wrap_back_run", bus.mode, 0);

    // Ring at 07:30:00, untouched until auto-stop.
    set_time(7, 29, 59); idle(1);
    set_time(7, 30, 0); idle(1);
    set_time(7, 30, 1);
    chk("ring_start", bus.ringing, 1);
    cnt = 0;
    for (int i = 0; i < 70 && bus.ringing; i++) begin cnt++; idle(1); end
    chk("ring_length", cnt, RING_TIMEOUT);
    chk("ring_stop_mode", bus.mode, 0);

    // Move alarm to 23:58 and snooze across midnight.
    press(B_MD); press(B_MD); press(B_MD);
    for (int i = 0; i < 16; i++) press(B_IN);
    press(B_MD);
    for (int i = 0; i < 28; i++) press(B_IN);
    press(B_MD);
    set_time(23, 58, 0); idle(1);
    set_time(23, 58, 1);
    chk("ring2_start", bus.ringing, 1);
    press(B_SN);
    chk("snooze_mode", bus.mode, 6);
    chk("snooze_quiet", bus.ringing, 0);
    set_time(23, 59, 0); idle(1);
    set_time(0, 2, 0); idle(1);
    set_time(0, 3, 1); idle(1);
    chk("snooze_no_early", bus.ringing, 0);
    set_time(0, 3, 0); idle(1);
    set_time(0, 3, 1);
    chk("snooze_ring", bus.ringing, 1);

    // alarm_en toggle beats snooze in RING.
    press(B_AE | B_SN);
    chk("dual_alarm_en", bus.alarm_en, 0);
    chk("dual_mode", bus.mode, 0);
    chk("dual_ringing", bus.ringing, 0);
    idle(2);
    chk("dual_stay_run", bus.mode, 0);

    // Asynchronous reset in SET_A_MIN.
    press(B_AE);
    press(B_MD); press(B_MD); press(B_MD); press(B_MD);
    chk("pre_reset_mode", bus.mode, 4);
    #1 reset = 1'b1;
    #1;
    chk("rst_mode", bus.mode, 0);
    chk("rst_alarm_time", bus.alarm_hr * 100 + bus.alarm_min, 0);
    chk("rst_alarm_en", bus.alarm_en, 0);
    chk("rst_load", bus.load, 0);
    @(posedge clk_1hz); #2;
    reset = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
